key_bounce_gen: RTL and testbench

//  Synthesizable emulator of a mechanical push-button: turns a one-cycle press request into a

---
 rtl/key_pkg.sv | 25 ++
 rtl/key_bounce_gen_if.sv | 29 ++
 rtl/key_bounce_gen_lfsr16.sv | 24 ++
 rtl/key_bounce_gen.sv | 123 ++++++++++++
 tb/tb_key_bounce_gen.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key emulator and the board key debouncer.
//   key_state_t    : phase of the emulated key waveform
//   LFSR_TAPS      : Galois feedback mask for the 16-bit bounce-gap LFSR
//   LFSR_DEF_SEED  : fallback seed, used whenever a zero seed is supplied
//   KEY_IDLE       : released level of a key line (keys are active-low)
//   lfsr_next()    : one Galois step of the LFSR
package key_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BNC_IN  = 2'd1,
      HOLD    = 2'd2,
      BNC_OUT = 2'd3
   } key_state_t;

   localparam logic [15:0] LFSR_TAPS     = 16'hB400;
   localparam logic [15:0] LFSR_DEF_SEED = 16'hACE1;
   localparam logic        KEY_IDLE      = 1'b1;

   // Right-shifting Galois form: the bit shifted out decides whether the taps are applied.
   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
   endfunction

endpackage

// File: rtl/key_bounce_gen_if.sv
// Request/status bundle of the key emulator.
//   press_i    : press request from the requester
//   ready_o    : emulator idle, a press is accepted in this cycle
//   busy_o     : press waveform in progress
//   done_o     : one-cycle pulse in the first idle cycle after a waveform
//   key_o      : emulated key line
//   dbg_state  : current FSM phase (observation only)
//   dbg_lfsr   : current LFSR value (observation only)
// Handshake: a press is taken at a rising clk edge exactly when press_i=1 and
// ready_o=1 in that cycle; press_i in any other cycle is dropped, never queued.
interface key_bounce_gen_if;
   logic                  press_i;
   logic                  ready_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  key_o;
   key_pkg::key_state_t   dbg_state;
   logic [15:0]           dbg_lfsr;

   modport master (
      output press_i,
      input  ready_o, busy_o, done_o, key_o, dbg_state, dbg_lfsr
   );

   modport slave (
      input  press_i,
      output ready_o, busy_o, done_o, key_o, dbg_state, dbg_lfsr
   );
endinterface

// File: rtl/key_bounce_gen_lfsr16.sv
// 16-bit Galois LFSR, advancing every cycle.
//   clk  : clock
//   rst  : synchronous active-high reset, loads seed
//   seed : reset value; zero would lock the register, so it is replaced by LFSR_DEF_SEED
//   q    : current LFSR value
module lfsr16
   import key_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] seed,
   output logic [15:0] q
);

   logic [15:0] seed_eff;

   assign seed_eff = (seed == 16'h0000) ? LFSR_DEF_SEED : seed;

   always_ff @(posedge clk) begin
      if (rst) q <= seed_eff;
      else     q <= lfsr_next(q);
   end

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical push-button emulator: an accepted press request becomes a key
// waveform with a bouncing press edge, a stable hold and a bouncing release.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : key_bounce_gen_if.slave (press_i, ready_o, busy_o, done_o, key_o, debug)
// Parameters: BOUNCE_CYC (bounce phase length), HOLD_CYC (stable pressed length),
// MAX_GAP_W (gap between bounce toggles = lfsr low bits + 1), IDLE_LEVEL, LFSR_SEED.
module key_bounce_gen
   import key_pkg::*;
#(
   parameter int          BOUNCE_CYC = 20,
   parameter int          HOLD_CYC   = 50,
   parameter int          MAX_GAP_W  = 3,
   parameter logic        IDLE_LEVEL = KEY_IDLE,
   parameter logic [15:0] LFSR_SEED  = LFSR_DEF_SEED
) (
   input  logic             clk,
   input  logic             rst,
   key_bounce_gen_if.slave  bus
);

   localparam int CNT_MAX = (BOUNCE_CYC > HOLD_CYC) ? BOUNCE_CYC : HOLD_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int GAP_W   = MAX_GAP_W + 1;

   key_state_t         state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [GAP_W-1:0]   gap, gap_n;
   logic               key, key_n;
   logic               done, done_n;
   logic [15:0]        lfsr;
   logic [GAP_W-1:0]   gap_load;

   lfsr16 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .seed (LFSR_SEED),
      .q    (lfsr)
   );

   // Gap of 1..2^MAX_GAP_W cycles; one extra bit so the +1 never wraps.
   assign gap_load = GAP_W'(lfsr[MAX_GAP_W-1:0]) + GAP_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         gap   <= '0;
         key   <= IDLE_LEVEL;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         gap   <= gap_n;
         key   <= key_n;
         done  <= done_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gap_n   = gap;
      key_n   = key;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            key_n = IDLE_LEVEL;
            if (bus.press_i) begin
               // First press edge is immediate; bouncing follows from the gap timer.
               state_n = BNC_IN;
               key_n   = ~IDLE_LEVEL;
               gap_n   = gap_load;
               cnt_n   = CNT_W'(BOUNCE_CYC - 1);
            end
         end
         BNC_IN, BNC_OUT: begin
            if (cnt == '0) begin
               // Phase end forces the settled level, truncating any pending gap.
               if (state == BNC_IN) begin
                  state_n = HOLD;
                  key_n   = ~IDLE_LEVEL;
                  cnt_n   = CNT_W'(HOLD_CYC - 1);
               end else begin
                  state_n = IDLE;
                  key_n   = IDLE_LEVEL;
                  done_n  = 1'b1;
               end
            end else begin
               cnt_n = cnt - CNT_W'(1);
               // Gap expires this cycle: toggle on the next edge and draw a new gap.
               if (gap == GAP_W'(1)) begin
                  key_n = ~key;
                  gap_n = gap_load;
               end else begin
                  gap_n = gap - GAP_W'(1);
               end
            end
         end
         HOLD: begin
            key_n = ~IDLE_LEVEL;
            if (cnt == '0) begin
               // Release edge lands on the first BNC_OUT cycle.
               state_n = BNC_OUT;
               key_n   = IDLE_LEVEL;
               gap_n   = gap_load;
               cnt_n   = CNT_W'(BOUNCE_CYC - 1);
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.ready_o   = (state == IDLE);
   assign bus.busy_o    = (state != IDLE);
   assign bus.done_o    = done;
   assign bus.key_o     = key;
   assign bus.dbg_state = state;
   assign bus.dbg_lfsr  = lfsr;

endmodule

// File: tb/tb_key_bounce_gen.sv
// Bench for key_bounce_gen: reset values, single press timing, bounce shape and
// repeatability, ignored presses while busy, mid-waveform reset, held press.
module tb_key_bounce_gen;
   import key_pkg::*;

   localparam int          BC      = 20;
   localparam int          HC      = 50;
   localparam int          GW      = 3;
   localparam logic [15:0] SEED    = 16'hACE1;
   localparam int          LEN     = 2 * BC + HC;   // busy length of one waveform
   localparam int          MAXRUN  = 1 << GW;
   localparam int          NCAP    = LEN + 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   key_bounce_gen_if bus ();

   key_bounce_gen #(
      .BOUNCE_CYC (BC),
      .HOLD_CYC   (HC),
      .MAX_GAP_W  (GW),
      .IDLE_LEVEL (1'b1),
      .LFSR_SEED  (SEED)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic key_w   [0:399];
   logic busy_w  [0:399];
   logic ready_w [0:399];
   logic done_w  [0:399];
   logic pz      [0:399];
   logic rz      [0:399];
   logic wave_a  [0:399];
   logic [15:0] exp_q [$];
   logic [15:0] got_q [$];

   // Reference LFSR: definition of a right-shifting Galois register with mask B400.
   function automatic logic [15:0] ref_step(input logic [15:0] v);
      logic out_bit;
      out_bit = v[0];
      v = v >> 1;
      if (out_bit) v = v ^ 16'hB400;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 400; i++) begin
         pz[i] = 1'b0;
         rz[i] = 1'b0;
      end
   endtask

   // Offset k is the k-th cycle after the start; pz/rz drive press/rst in that cycle.
   task automatic capture(input int n);
      for (int k = 0; k < n; k++) begin
         key_w[k]    = bus.key_o;
         busy_w[k]   = bus.busy_o;
         ready_w[k]  = bus.ready_o;
         done_w[k]   = bus.done_o;
         bus.press_i = pz[k];
         rst         = rz[k];
         tick();
      end
      bus.press_i = 1'b0;
      rst         = 1'b0;
   endtask

   task automatic idle_wait();
      repeat ($urandom_range(0, 7)) tick();
   endtask

   // Checks a captured single waveform that was accepted at offset 0.
   task automatic check_single(input string tag);
      int busy_err, key_err, done_cnt;
      int toggles, run, maxrun, p;
      busy_err = 0; key_err = 0; done_cnt = 0;
      for (int k = 0; k < NCAP; k++) begin
         if (busy_w[k] !== ((k >= 1 && k <= LEN) ? 1'b1 : 1'b0)) busy_err++;
         if (ready_w[k] !== ((k >= 1 && k <= LEN) ? 1'b0 : 1'b1)) busy_err++;
         if (done_w[k] === 1'b1) done_cnt++;
         if ((k == 0 || k > LEN) && key_w[k] !== 1'b1) key_err++;
         if (k == 1 && key_w[k] !== 1'b0) key_err++;
         if (k >= BC + 1 && k <= BC + HC && key_w[k] !== 1'b0) key_err++;
         if (k == BC + HC + 1 && key_w[k] !== 1'b1) key_err++;
      end
      total++;
      if (busy_err != 0) begin
         bad++;
         $display("FAIL %s busy/ready window: %0d wrong cycles, required 0", tag, busy_err);
      end
      total++;
      if (key_err != 0) begin
         bad++;
         $display("FAIL %s key levels: %0d wrong cycles, required 0", tag, key_err);
      end
      total++;
      if (done_cnt != 1 || done_w[LEN + 1] !== 1'b1) begin
         bad++;
         $display("FAIL %s done pulse: count=%0d at_%0d=%b, required count=1 at_%0d=1",
                  tag, done_cnt, LEN + 1, done_w[LEN + 1], LEN + 1);
      end
      for (int ph = 0; ph < 2; ph++) begin
         p = (ph == 0) ? 1 : BC + HC + 1;
         toggles = 0; run = 1; maxrun = 1;
         for (int k = p + 1; k < p + BC; k++) begin
            if (key_w[k] !== key_w[k - 1]) begin
               toggles++;
               run = 1;
            end else begin
               run++;
            end
            if (run > maxrun) maxrun = run;
         end
         total++;
         if (toggles < 1 || maxrun > MAXRUN) begin
            bad++;
            $display("FAIL %s bounce phase %0d: toggles=%0d maxrun=%0d, required toggles>=1 maxrun<=%0d",
                     tag, ph, toggles, maxrun, MAXRUN);
         end
      end
   endtask

   task automatic test_reset();
      logic [15:0] m;
      int lf_err;
      rst = 1'b1;
      bus.press_i = 1'b0;
      repeat (3) tick();
      total++;
      if (bus.key_o !== 1'b1 || bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 ||
          bus.done_o !== 1'b0 || bus.dbg_state !== IDLE) begin
         bad++;
         $display("FAIL reset outputs: key=%b ready=%b busy=%b done=%b, required 1 1 0 0",
                  bus.key_o, bus.ready_o, bus.busy_o, bus.done_o);
      end
      total++;
      if (bus.dbg_lfsr !== SEED) begin
         bad++;
         $display("FAIL reset lfsr: got %h, required %h", bus.dbg_lfsr, SEED);
      end
      rst = 1'b0;
      m = SEED;
      lf_err = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         m = ref_step(m);
         if (bus.dbg_lfsr !== m) lf_err++;
      end
      total++;
      if (lf_err != 0) begin
         bad++;
         $display("FAIL lfsr sequence: %0d wrong steps, required 0", lf_err);
      end
   endtask

   task automatic test_single_press();
      for (int r = 0; r < 2; r++) begin
         idle_wait();
         clear_sched();
         pz[0] = 1'b1;
         capture(NCAP);
         check_single($sformatf("single%0d", r));
      end
   endtask

   task automatic test_repeatable();
      int k_idle, diff;
      k_idle = $urandom_range(0, 30);
      for (int r = 0; r < 2; r++) begin
         rst = 1'b1;
         repeat (2) tick();
         rst = 1'b0;
         repeat (k_idle) tick();
         clear_sched();
         pz[0] = 1'b1;
         capture(NCAP);
         check_single($sformatf("seeded%0d", r));
         if (r == 0) begin
            for (int k = 0; k < NCAP; k++) wave_a[k] = key_w[k];
         end
      end
      diff = 0;
      for (int k = 0; k < NCAP; k++) if (wave_a[k] !== key_w[k]) diff++;
      total++;
      if (diff != 0) begin
         bad++;
         $display("FAIL repeat waveform: %0d differing cycles, required 0", diff);
      end
   endtask

   task automatic test_busy_press();
      idle_wait();
      clear_sched();
      pz[0]  = 1'b1;
      pz[5]  = 1'b1;
      pz[60] = 1'b1;
      for (int i = 0; i < 6; i++) pz[$urandom_range(1, LEN)] = 1'b1;
      capture(NCAP);
      check_single("busy_press");
   endtask

   task automatic test_mid_reset();
      int done_cnt;
      idle_wait();
      clear_sched();
      pz[0]  = 1'b1;
      rz[40] = 1'b1;
      capture(NCAP);
      total++;
      if (key_w[41] !== 1'b1 || ready_w[41] !== 1'b1 || busy_w[41] !== 1'b0) begin
         bad++;
         $display("FAIL mid reset: key=%b ready=%b busy=%b, required 1 1 0",
                  key_w[41], ready_w[41], busy_w[41]);
      end
      done_cnt = 0;
      for (int k = 0; k < NCAP; k++) if (done_w[k] === 1'b1) done_cnt++;
      total++;
      if (done_cnt != 0) begin
         bad++;
         $display("FAIL mid reset done: count=%0d, required 0", done_cnt);
      end
      idle_wait();
      clear_sched();
      pz[0] = 1'b1;
      capture(NCAP);
      check_single("after_reset");
   endtask

   task automatic test_back_to_back();
      int ok;
      clear_sched();
      for (int k = 0; k < 300; k++) pz[k] = 1'b1;
      exp_q.delete();
      got_q.delete();
      for (int a = 0; a < 300; a += LEN + 1) exp_q.push_back(16'(a));
      capture(310);
      for (int k = 0; k < 310; k++)
         if (ready_w[k] === 1'b1 && pz[k] === 1'b1) got_q.push_back(16'(k));
      ok = (got_q.size() == exp_q.size());
      if (ok) for (int i = 0; i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) ok = 0;
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL held press accepts: got %0d accepts first=%0d, required %0d accepts at multiples of %0d",
                  got_q.size(), (got_q.size() > 0) ? int'(got_q[0]) : -1, exp_q.size(), LEN + 1);
      end
      ok = 1;
      for (int k = 0; k < 310; k++) begin
         if (done_w[k] !== ((k > 0 && k % (LEN + 1) == 0) ? 1'b1 : 1'b0)) ok = 0;
         if (done_w[k] === 1'b1 && (key_w[k] !== 1'b1 || ready_w[k] !== 1'b1)) ok = 0;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL held press done pulses: pattern wrong, required one per %0d cycles with key=1 ready=1",
                  LEN + 1);
      end
      // Drain the last accepted waveform.
      repeat (LEN + 2) tick();
   endtask

   initial begin
      bus.press_i = 1'b0;
      test_reset();
      test_single_press();
      test_repeatable();
      test_busy_press();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
